mult_hilo_ctrl: RTL and testbench
=================================

// Module: mult_hilo_ctrl
// PURPOSE
//  Sequencer for the iterative (radix-2 shift-add) MULT/MULTU unit and HI/LO registers in the MIPS pipeline.
//  Accepts a multiply from decode, runs WIDTH iterations, then writes HI/LO.
//  Drives the multiply-stall request into hazard_unit, interlocking MFHI/MFLO and back-to-back multiplies.
//  Honours the hazard unit's flush.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH; HI/LO each WIDTH bits
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low (0 = reset)
//  start      in   1      multiply issued from decode (MultD)
//  is_signed  in   1      1 = MULT, 0 = MULTU; sampled with start
//  src_a      in   WIDTH  multiplicand; sampled with start
//  src_b      in   WIDTH  multiplier; sampled with start
//  flush      in   1      from hazard_unit; aborts an in-flight multiply
//  mfhi_req   in   1      MFHI in decode
//  mflo_req   in   1      MFLO in decode
//  stall_req  out  1      to hazard_unit "multiply" input
//  busy       out  1      state != IDLE
//  done       out  1      1-cycle pulse in DONE
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, count=0, accumulators=0, hi=lo=0; busy=done=stall_req=0.
//  FSM states: IDLE=2'b00, BUSY=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE.
//  IDLE:
//   - start=1 & flush=0: latch |src_a|, |src_b| (magnitudes when is_signed, else raw).
//   - Latch neg = is_signed & (a[W-1]^b[W-1]); acc={W{0}},mplier; count=0; -> BUSY.
//  BUSY, each cycle:
//   - if mplier LSB=1, upper acc += mcand (W+1-bit add, carry kept).
//   - Shift {carry,acc} right 1; count++.
//   - At count==WIDTH-1 -> DONE, so BUSY lasts exactly WIDTH cycles.
//  DONE:
//   - done=1; result = neg ? -acc : acc, 2W-bit two's complement.
//   - At the clock edge: hi<=result[2W-1:W], lo<=result[W-1:0]; -> IDLE.
//  Latency: start high in cycle 0 -> BUSY cycles 1..WIDTH -> DONE cycle WIDTH+1 -> new hi/lo visible from cycle WIDTH+2.
//  stall_req = busy & (start | mfhi_req | mflo_req), combinational.
//   - A start arriving while busy is ignored. Decode holds it under stall and reissues it in IDLE.
//  flush=1 in BUSY or DONE:
//   - -> IDLE at the next edge; hi/lo keep their old values; done is not asserted in the following cycle.
//   - flush dominates start in IDLE.
//  Boundaries:
//   - Zero operands still take WIDTH cycles.
//   - MULT with -2^(W-1) is handled: the magnitude fits unsigned in W bits.
//   - mfhi/mflo in IDLE never stall.
//  Reset mid-operation: immediate return to reset values; a partial result is never written.
// STRUCTURE
//  - Shared package/include mips_pkg:
//     - FSM state encodings MULT_IDLE/MULT_BUSY/MULT_DONE.
//     - Default WIDTH=32.
//     - Count width $clog2(WIDTH).
//  - Sub-module mult_step (combinational):
//     - Inputs {acc, mplier, mcand}; output next {acc, mplier}, one shift-add iteration.
//     - Instantiated once and registered by the FSM.
//  - FSM, counter, sign fix-up and HI/LO registers live in mult_hilo_ctrl.
// TESTING
//  1. MULTU 3*5, start cycle 0 -> busy cycles 1..33; done=1 in cycle 33; hi=0, lo=0x0000000F from cycle 34.
//  2. MULT -3*7 (0xFFFFFFFD, 7) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF^2 -> hi=0xFFFFFFFE, lo=0x00000001.
//  3. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
//     MULTU 0*0x12345678 -> hi=lo=0, still 33 busy cycles.
//  4. Preload hi/lo via test 1, start 6*7, flush in cycle 10:
//     - busy=0 from cycle 11; done never pulses; hi=0, lo=0xF unchanged.
//  5. mfhi_req held from cycle 5 -> stall_req=1 cycles 5..33, 0 in cycle 34.
//     Second start in cycle 3 -> stall_req=1; ignored until IDLE.
//  6. reset=0 in cycle 20 mid-multiply -> busy, done, stall_req, hi, lo all 0 immediately.
//     Release, then MULTU 2*2 -> lo=4.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/HI-LO sequencer.
//   MULT_WIDTH   : default operand width
//   MULT_CNT_W   : iteration counter width for the default operand width
//   mult_state_t : sequencer state encoding (2'b11 is unused and recovers to IDLE)
//   mult_cnt_w() : counter width for an arbitrary operand width
package mips_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH);

  typedef enum logic [1:0] {
    MULT_IDLE = 2'b00,
    MULT_BUSY = 2'b01,
    MULT_DONE = 2'b10
  } mult_state_t;

  // A counter is never narrower than one bit, even for WIDTH == 1.
  function automatic int mult_cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2 shift-add iteration of an unsigned multiplier.
//   i_acc     : upper half of the running product
//   i_mplier  : lower half of the running product, holding the unconsumed multiplier bits
//   i_mcand   : multiplicand
//   o_acc     : next upper half
//   o_mplier  : next lower half
// The add is WIDTH+1 bits wide so the carry shifts back into the top of the accumulator.
module mult_step
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_mplier,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mplier
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = {1'b0, i_acc};
    if (i_mplier[0]) begin
      w_sum = {1'b0, i_acc} + {1'b0, i_mcand};
    end
    o_acc    = w_sum[WIDTH:1];
    o_mplier = {w_sum[0], i_mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// Sequencer for the iterative MULT/MULTU unit and the HI/LO registers.
//   clk        : rising-edge clock
//   reset      : asynchronous reset, active low
//   start      : multiply issued from decode; sampled in IDLE only
//   is_signed  : 1 = MULT, 0 = MULTU; sampled with start
//   src_a      : multiplicand; sampled with start
//   src_b      : multiplier; sampled with start
//   flush      : abandons an in-flight multiply, HI/LO untouched
//   mfhi_req   : MFHI in decode
//   mflo_req   : MFLO in decode
//   stall_req  : multiply interlock request to the hazard unit
//   busy       : sequencer not in IDLE
//   done       : one-cycle pulse while the result is being written
//   hi, lo     : HI/LO registers
// Operands are reduced to magnitudes, multiplied unsigned over WIDTH cycles,
// and the sign is restored in DONE just before HI/LO are written.
module mult_hilo_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             mfhi_req,
  input  logic             mflo_req,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = mult_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mult_state_t        r_state;
  mult_state_t        w_next_state;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_neg;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_neg;
  logic [WIDTH-1:0]   w_step_acc;
  logic [WIDTH-1:0]   w_step_mplier;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_result;

  // Magnitude of -2^(W-1) wraps to 2^(W-1), which is exact as an unsigned value.
  always_comb begin
    w_mag_a = (is_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    w_mag_b = (is_signed && src_b[WIDTH-1]) ? -src_b : src_b;
    w_neg   = is_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
  end

  mult_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_acc    (r_acc),
    .i_mplier (r_mplier),
    .i_mcand  (r_mcand),
    .o_acc    (w_step_acc),
    .o_mplier (w_step_mplier)
  );

  assign w_prod   = {r_acc, r_mplier};
  assign w_result = r_neg ? -w_prod : w_prod;

  always_comb begin
    w_next_state = MULT_IDLE;
    case (r_state)
      MULT_IDLE: w_next_state = (start && !flush) ? MULT_BUSY : MULT_IDLE;
      MULT_BUSY: begin
        if (flush) begin
          w_next_state = MULT_IDLE;
        end else if (r_count == LAST_CNT) begin
          w_next_state = MULT_DONE;
        end else begin
          w_next_state = MULT_BUSY;
        end
      end
      MULT_DONE: w_next_state = MULT_IDLE;
      default:   w_next_state = MULT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= MULT_IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        MULT_IDLE: begin
          if (start && !flush) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_acc    <= '0;
            r_neg    <= w_neg;
            r_count  <= '0;
          end
        end
        MULT_BUSY: begin
          if (!flush) begin
            r_acc    <= w_step_acc;
            r_mplier <= w_step_mplier;
            r_count  <= r_count + CNT_W'(1);
          end
        end
        MULT_DONE: begin
          // A flush arriving with the result still drops it.
          if (!flush) begin
            r_hi <= w_result[2*WIDTH-1:WIDTH];
            r_lo <= w_result[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != MULT_IDLE);
  assign done      = (r_state == MULT_DONE);
  assign stall_req = busy & (start | mfhi_req | mflo_req);
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Bench for mult_hilo_ctrl: directed multiplies with hand-computed HI/LO,
// a queue of expected results drained by an independent monitor, plus
// timing, interlock, flush and reset checks from the stimulus process.
module tb_mult_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        mfhi_req;
  logic        mflo_req;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  bit          pending  = 1'b0;

  always #5 clk = ~clk;

  mult_hilo_ctrl #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .mfhi_req  (mfhi_req),
    .mflo_req  (mflo_req),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: done in one cycle means HI/LO must hold the queued result in the next.
  always @(negedge clk) begin
    if (!reset) begin
      pending = 1'b0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'({hi, lo}), 64'h0);
          if ({hi, lo} == 64'h0) begin
            n_fail++;
            $display("FAIL unexpected_done: got done pulse, expected none");
          end
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("hilo_result", {hi, lo}, e);
        end
      end
      if (done) pending = 1'b1;
    end
  end

  // Issues a multiply in the current cycle (cycle 0); returns in cycle 1 after the edge.
  task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] eh, input logic [31:0] el,
                          output bit busy0);
    start = 1'b1; is_signed = s; src_a = a; src_b = b;
    if (push) exp_q.push_back({eh, el});
    @(negedge clk);
    busy0 = busy;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Steps cycles 1.. until the sequencer is idle, applying optional events.
  task automatic run_op(input int flush_at, input int start2_at, input int mfhi_from,
                        output int nbusy, output int done_cyc, output int stall_cnt,
                        output bit stall_s2, output bit stall_idle);
    nbusy = 0; done_cyc = -1; stall_cnt = 0; stall_s2 = 1'b0; stall_idle = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      start    = (c == start2_at);
      flush    = (c == flush_at);
      mfhi_req = (mfhi_from > 0) && (c >= mfhi_from);
      @(negedge clk);
      if (busy) nbusy++;
      if (done) done_cyc = c;
      if (stall_req) stall_cnt++;
      if (c == start2_at) stall_s2 = stall_req;
      if (!busy) begin
        stall_idle = stall_req;
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0; mfhi_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic simple_op(input string name, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    bit b0, s2, si;
    int nb, dc, sc;
    start_op(s, a, b, 1'b1, eh, el, b0);
    run_op(0, 0, 0, nb, dc, sc, s2, si);
    check({name, "_busy_cycles"}, 64'(nb), 64'd33);
  endtask

  initial begin
    bit b0, s2, si;
    int nb, dc, sc;

    reset = 1'b0; start = 1'b0; is_signed = 1'b0; src_a = '0; src_b = '0;
    flush = 1'b0; mfhi_req = 1'b0; mflo_req = 1'b0;
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit b0, s2, si;
    int nb, dc, sc;

    #1;
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; src_a = '0; src_b = '0;
    flush = 1'b0; mfhi_req = 1'b0; mflo_req = 1'b1;
    @(negedge clk);
    check("reset_outputs", 64'({busy, done, stall_req}), 64'd0);
    check("reset_hilo", 64'({hi, lo}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("mflo_idle_no_stall", 64'(stall_req), 64'd0);
    mflo_req = 1'b0;
    @(posedge clk); #1;

    // 1: MULTU 3*5 with full latency profile.
    start_op(1'b0, 32'd3, 32'd5, 1'b1, 32'h0, 32'hF, b0);
    check("t1_busy_cycle0", 64'(b0), 64'd0);
    run_op(0, 0, 0, nb, dc, sc, s2, si);
    check("t1_busy_cycles", 64'(nb), 64'd33);
    check("t1_done_cycle", 64'(dc), 64'd33);

    // 2, 3: signed, unsigned and boundary operands.
    simple_op("mult_m3x7", 1'b1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    simple_op("multu_max_sq", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    simple_op("mult_min_sq", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    simple_op("mult_min_x1", 1'b1, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000);
    simple_op("mult_m1xm1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1);
    simple_op("multu_zero", 1'b0, 32'h0, 32'h12345678, 32'h0, 32'h0);
    simple_op("multu_3x5", 1'b0, 32'd3, 32'd5, 32'h0, 32'hF);

    // 4: flush in cycle 10 leaves HI/LO at 0/0xF and no done pulse.
    start_op(1'b0, 32'd6, 32'd7, 1'b0, 32'h0, 32'h0, b0);
    run_op(10, 0, 0, nb, dc, sc, s2, si);
    check("t4_busy_cycles", 64'(nb), 64'd10);
    check("t4_done_cycle", 64'(dc), 64'hFFFFFFFF_FFFFFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("t4_hilo_kept", 64'({hi, lo}), 64'h0000000F);

    // 5: interlock on a second start and on a held MFHI.
    start_op(1'b0, 32'h00010000, 32'h00010000, 1'b1, 32'h1, 32'h0, b0);
    run_op(0, 3, 5, nb, dc, sc, s2, si);
    check("t5_stall_restart", 64'(s2), 64'd1);
    check("t5_stall_cycles", 64'(sc), 64'd30);
    check("t5_stall_idle", 64'(si), 64'd0);
    check("t5_busy_cycles", 64'(nb), 64'd33);

    // 6: reset in cycle 20 clears everything immediately.
    start_op(1'b0, 32'd9, 32'd9, 1'b0, 32'h0, 32'h0, b0);
    for (int c = 1; c < 20; c++) @(posedge clk);
    #1;
    mfhi_req = 1'b1;
    #1;
    check("t6_pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("t6_reset_ctrl", 64'({busy, done, stall_req}), 64'd0);
    check("t6_reset_hilo", 64'({hi, lo}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; mfhi_req = 1'b0;
    @(posedge clk); #1;
    simple_op("t6_multu_2x2", 1'b0, 32'd2, 32'd2, 32'h0, 32'h4);

    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
